// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: predictor counter
// encodings and PC constants.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/if_fetch_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters:
// combinational lookup, clocked training from EX.
module btb_predictor
  import if_fetch_unit_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lkp_pc,
  output logic        lkp_taken,
  output logic [31:0] lkp_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_is_jump
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] valid_mem;
  logic [TAG_W-1:0]       tag_mem    [BTB_ENTRIES];
  logic [31:0]            target_mem [BTB_ENTRIES];
  ctr_e                   ctr_mem    [BTB_ENTRIES];

  logic [IDX_W-1:0] lkp_idx;
  logic [TAG_W-1:0] lkp_tag;
  logic             lkp_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  function automatic ctr_e sat_inc(input ctr_e c);
    logic [1:0] t;
    t = c;
    if (t != 2'b11) t = t + 2'd1;
    return ctr_e'(t);
  endfunction

  function automatic ctr_e sat_dec(input ctr_e c);
    logic [1:0] t;
    t = c;
    if (t != 2'b00) t = t - 2'd1;
    return ctr_e'(t);
  endfunction

  assign lkp_idx    = lkp_pc[IDX_W+1:2];
  assign lkp_tag    = lkp_pc[31:IDX_W+2];
  assign lkp_hit    = valid_mem[lkp_idx] && (tag_mem[lkp_idx] == lkp_tag);
  assign lkp_taken  = lkp_hit && ctr_mem[lkp_idx][1];
  assign lkp_target = target_mem[lkp_idx];

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign upd_hit = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  // Valid bits are the only control state; clearing them invalidates the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_mem <= '0;
    end else if (upd_valid && !upd_hit && upd_taken) begin
      valid_mem[upd_idx] <= 1'b1;
    end
  end

  // Entry payload needs no reset: it is ignored while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (upd_valid && !rst) begin
      if (upd_hit) begin
        if (upd_is_jump)    ctr_mem[upd_idx] <= ST;
        else if (upd_taken) ctr_mem[upd_idx] <= sat_inc(ctr_mem[upd_idx]);
        else                ctr_mem[upd_idx] <= sat_dec(ctr_mem[upd_idx]);
        if (upd_taken) target_mem[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_mem[upd_idx]    <= upd_tag;
        target_mem[upd_idx] <= upd_target;
        ctr_mem[upd_idx]    <= upd_is_jump ? ST : WT;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and BTB-based
// branch prediction feeding the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_en,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_upd_valid,
  input  logic [31:0] ex_upd_pc,
  input  logic        ex_upd_taken,
  input  logic [31:0] ex_upd_target,
  input  logic        ex_upd_is_jump,
  output logic [31:0] imem_addr,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target
);

  logic [31:0] pc_reg;
  logic [31:0] pc_seq;
  logic        btb_taken;
  logic [31:0] btb_target;

  btb_predictor #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lkp_pc     (pc_reg),
    .lkp_taken  (btb_taken),
    .lkp_target (btb_target),
    .upd_valid  (ex_upd_valid),
    .upd_pc     (ex_upd_pc),
    .upd_taken  (ex_upd_taken),
    .upd_target (ex_upd_target),
    .upd_is_jump(ex_upd_is_jump)
  );

  assign pc_seq         = pc_reg + PC_INC;
  assign if_pred_taken  = btb_taken;
  assign if_pred_target = btb_taken ? btb_target : pc_seq;
  assign if_pc          = pc_reg;
  assign imem_addr      = pc_reg;

  // EX redirect overrides a stall; a stall overrides the prediction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pc_reg <= RESET_PC;
    else if (ex_redirect) pc_reg <= ex_redirect_pc;
    else if (pipeline_en) pc_reg <= if_pred_target;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector bench for if_fetch_unit with a few hand-written sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeline_en;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        ex_upd_valid;
  logic [31:0] ex_upd_pc;
  logic        ex_upd_taken;
  logic [31:0] ex_upd_target;
  logic        ex_upd_is_jump;
  logic [31:0] imem_addr;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;

  int checks   = 0;
  int failures = 0;

  if_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .BTB_ENTRIES(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pipeline_en   (pipeline_en),
    .ex_redirect   (ex_redirect),
    .ex_redirect_pc(ex_redirect_pc),
    .ex_upd_valid  (ex_upd_valid),
    .ex_upd_pc     (ex_upd_pc),
    .ex_upd_taken  (ex_upd_taken),
    .ex_upd_target (ex_upd_target),
    .ex_upd_is_jump(ex_upd_is_jump),
    .imem_addr     (imem_addr),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .if_pred_target(if_pred_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        red;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uj;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic red, input logic [31:0] rpc,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic uj,
                     input logic [31:0] e_pc, input logic e_pt, input logic [31:0] e_tgt);
    vec_t v;
    v = '{en, red, rpc, uv, upc, ut, utgt, uj, e_pc, e_pt, e_tgt};
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name, input logic [31:0] e_pc,
                           input logic e_pt, input logic [31:0] e_tgt);
    checks++;
    if (if_pc !== e_pc || imem_addr !== e_pc) begin
      failures++;
      $display("FAIL %s pc: got if_pc=%h imem_addr=%h expected %h", name, if_pc, imem_addr, e_pc);
    end
    checks++;
    if (if_pred_taken !== e_pt) begin
      failures++;
      $display("FAIL %s pred_taken: got %b expected %b", name, if_pred_taken, e_pt);
    end
    checks++;
    if (if_pred_target !== e_tgt) begin
      failures++;
      $display("FAIL %s pred_target: got %h expected %h", name, if_pred_target, e_tgt);
    end
  endtask

  task automatic drive_idle();
    pipeline_en    = 1'b0;
    ex_redirect    = 1'b0;
    ex_redirect_pc = '0;
    ex_upd_valid   = 1'b0;
    ex_upd_pc      = '0;
    ex_upd_taken   = 1'b0;
    ex_upd_target  = '0;
    ex_upd_is_jump = 1'b0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;

    //   en  red rpc           uv  upc    ut  utgt   uj   e_pc          pt  e_tgt
    add(1, 0, 32'h0,        0, 32'h0,  0, 32'h0,   0, 32'h0,         0, 32'h4);
    add(1, 0, 32'h0,        0, 32'h0,  0, 32'h0,   0, 32'h4,         0, 32'h8);
    add(1, 0, 32'h0,        0, 32'h0,  0, 32'h0,   0, 32'h8,         0, 32'hC);
    add(1, 1, 32'h8,        0, 32'h0,  0, 32'h0,   0, 32'hC,         0, 32'h10);
    add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   0, 32'h8,         0, 32'hC);
    add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   0, 32'h8,         0, 32'hC);
    add(0, 1, 32'h40,       0, 32'h0,  0, 32'h0,   0, 32'h8,         0, 32'hC);
    add(1, 0, 32'h0,        1, 32'h10, 1, 32'h80,  0, 32'h40,        0, 32'h44);
    add(1, 1, 32'h10,       0, 32'h0,  0, 32'h0,   0, 32'h44,        0, 32'h48);
    add(1, 0, 32'h0,        0, 32'h0,  0, 32'h0,   0, 32'h10,        1, 32'h80);
    add(0, 0, 32'h0,        1, 32'h10, 0, 32'h0,   0, 32'h80,        0, 32'h84);
    add(0, 1, 32'h10,       1, 32'h10, 0, 32'h0,   0, 32'h80,        0, 32'h84);
    add(1, 0, 32'h0,        1, 32'h10, 1, 32'h80,  0, 32'h10,        0, 32'h14);
    add(1, 1, 32'h10,       0, 32'h0,  0, 32'h0,   0, 32'h14,        0, 32'h18);
    add(0, 0, 32'h0,        1, 32'h10, 1, 32'h90,  0, 32'h10,        0, 32'h14);
    add(0, 0, 32'h0,        1, 32'h50, 1, 32'hA0,  0, 32'h10,        1, 32'h90);
    add(0, 1, 32'h50,       0, 32'h0,  0, 32'h0,   0, 32'h10,        0, 32'h14);
    add(1, 0, 32'h0,        0, 32'h0,  0, 32'h0,   0, 32'h50,        1, 32'hA0);
    add(0, 1, 32'h20,       0, 32'h0,  0, 32'h0,   0, 32'hA0,        0, 32'hA4);
    add(0, 0, 32'h0,        1, 32'h20, 1, 32'h100, 1, 32'h20,        0, 32'h24);
    add(0, 0, 32'h0,        1, 32'h20, 0, 32'h0,   0, 32'h20,        1, 32'h100);
    add(0, 0, 32'h0,        1, 32'h20, 0, 32'h0,   0, 32'h20,        1, 32'h100);
    add(0, 0, 32'h0,        1, 32'h20, 1, 32'h104, 1, 32'h20,        0, 32'h24);
    add(1, 1, 32'h60,       0, 32'h0,  0, 32'h0,   0, 32'h20,        1, 32'h104);
    add(0, 1, 32'h20,       1, 32'h60, 0, 32'h0,   0, 32'h60,        0, 32'h64);
    add(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0,   0, 32'h20,        1, 32'h104);
    add(1, 0, 32'h0,        0, 32'h0,  0, 32'h0,   0, 32'hFFFF_FFFC, 0, 32'h0);
    add(1, 1, 32'h2,        0, 32'h0,  0, 32'h0,   0, 32'h0,         0, 32'h4);
    add(1, 0, 32'h0,        0, 32'h0,  0, 32'h0,   0, 32'h2,         0, 32'h6);
    add(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,   0, 32'h6,         0, 32'hA);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("reset", 32'h0, 1'b0, 32'h4);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      pipeline_en    = vecs[i].en;
      ex_redirect    = vecs[i].red;
      ex_redirect_pc = vecs[i].rpc;
      ex_upd_valid   = vecs[i].uv;
      ex_upd_pc      = vecs[i].upc;
      ex_upd_taken   = vecs[i].ut;
      ex_upd_target  = vecs[i].utgt;
      ex_upd_is_jump = vecs[i].uj;
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pt, vecs[i].e_tgt);
    end

    // Asynchronous reset mid-run, with training in flight
    @(negedge clk);
    drive_idle();
    pipeline_en   = 1'b1;
    ex_upd_valid  = 1'b1;
    ex_upd_pc     = 32'h10;
    ex_upd_taken  = 1'b1;
    ex_upd_target = 32'h200;
    #2 rst = 1'b1;
    #1 check_out("async_rst", 32'h0, 1'b0, 32'h4);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    #1 check_out("after_rst", 32'h0, 1'b0, 32'h4);

    // Previously trained entries must all be gone
    ex_redirect    = 1'b1;
    ex_redirect_pc = 32'h20;
    @(negedge clk);
    ex_redirect_pc = 32'h50;
    #1 check_out("rst_inval_20", 32'h20, 1'b0, 32'h24);
    @(negedge clk);
    ex_redirect_pc = 32'h10;
    #1 check_out("rst_inval_50", 32'h50, 1'b0, 32'h54);
    @(negedge clk);
    ex_redirect = 1'b0;
    #1 check_out("rst_inval_10", 32'h10, 1'b0, 32'h14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
